// File: rtl/sdram_ls_arb.sv
// sdram_ls_arb: round-robin arbiter sharing the SDRAM low-speed write port between N toggle-handshake requesters.
module sdram_ls_arb #(
    parameter int N        = 3,
    parameter int AW       = 25,
    parameter int DW       = 32,
    parameter int ACK_SYNC = 2
) (
    input  logic            CLK,
    input  logic            RESn,
    input  logic [N-1:0]    REQ_TGL,
    input  logic [N*AW-1:0] REQ_A,
    input  logic [N*DW-1:0] REQ_D,
    output logic [N-1:0]    ACK_TGL,
    output logic [AW-1:0]   LS_WADDR,
    output logic [DW-1:0]   LS_DIN,
    output logic            LS_WE_REQ,
    input  logic            LS_WE_ACK,
    output logic            BUSY,
    output logic [2:0]      GRANT
);
    localparam int CW = $clog2(ACK_SYNC + 2);

    typedef enum logic [1:0] {ST_ALIGN, ST_IDLE, ST_WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ptr_q, ptr_d, grant_q, grant_d, win, off;
    logic [3:0]      sum;
    logic [N-1:0]    ack_tgl_q, ack_tgl_d, pend;
    logic [2*N-1:0]  rot;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            req_q, req_d, busy_q, busy_d, hit, ack_s;

    generate
        if (ACK_SYNC == 0) begin : g_nosync
            assign ack_s = LS_WE_ACK;
        end else begin : g_sync
            logic [ACK_SYNC-1:0] sync_q;
            always_ff @(posedge CLK or negedge RESn)
                if (!RESn) sync_q <= '0;
                else       sync_q <= ACK_SYNC'({sync_q, LS_WE_ACK});
            assign ack_s = sync_q[ACK_SYNC-1];
        end
    endgenerate

    assign pend = REQ_TGL ^ ack_tgl_q;

    // Rotate pending bits so bit 0 is the index just after the pointer; lowest set bit wins.
    always_comb begin
        rot = {pend, pend} >> (ptr_q + 3'd1);
        hit = 1'b0;
        off = '0;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) begin
                hit = 1'b1;
                off = 3'(j);
            end
        sum = 4'(ptr_q) + 4'(off) + 4'd1;
        win = 3'(sum >= 4'(N) ? sum - 4'(N) : sum);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        ack_tgl_d = ack_tgl_q;
        waddr_d   = waddr_q;
        din_d     = din_q;
        req_d     = req_q;
        busy_d    = busy_q;
        case (state_q)
            ST_ALIGN:
                if (cnt_q == CW'(ACK_SYNC)) begin
                    req_d   = ack_s;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            ST_IDLE:
                if (hit) begin
                    waddr_d = REQ_A[int'(win)*AW +: AW];
                    din_d   = REQ_D[int'(win)*DW +: DW];
                    req_d   = ~req_q;
                    grant_d = win;
                    ptr_d   = win;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            ST_WAIT:
                if (ack_s == req_q) begin
                    ack_tgl_d = ack_tgl_q ^ (N'(1) << grant_q);
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            default: state_d = ST_ALIGN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q   <= ST_ALIGN;
            cnt_q     <= '0;
            ptr_q     <= 3'(N - 1);
            grant_q   <= '0;
            ack_tgl_q <= '0;
            waddr_q   <= '0;
            din_q     <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            ack_tgl_q <= ack_tgl_d;
            waddr_q   <= waddr_d;
            din_q     <= din_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
        end
    end

    assign ACK_TGL   = ack_tgl_q;
    assign LS_WADDR  = waddr_q;
    assign LS_DIN    = din_q;
    assign LS_WE_REQ = req_q;
    assign BUSY      = busy_q;
    assign GRANT     = grant_q;
endmodule

// File: tb/tb_sdram_ls_arb.sv
// tb_sdram_ls_arb: directed bench for sdram_ls_arb, one instance without ack sync and one with a 2-stage sync.
module tb_sdram_ls_arb;
    localparam int N = 3, AW = 25, DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            a_resn, a_we_ack, a_we_req, a_busy;
    logic [N-1:0]    a_req, a_ack;
    logic [N*AW-1:0] a_addr;
    logic [N*DW-1:0] a_data;
    logic [AW-1:0]   a_waddr;
    logic [DW-1:0]   a_din;
    logic [2:0]      a_grant;

    logic            b_resn, b_we_ack, b_we_req, b_busy;
    logic [N-1:0]    b_req, b_ack;
    logic [N*AW-1:0] b_addr;
    logic [N*DW-1:0] b_data;
    logic [AW-1:0]   b_waddr;
    logic [DW-1:0]   b_din;
    logic [2:0]      b_grant;

    sdram_ls_arb #(.N(N), .AW(AW), .DW(DW), .ACK_SYNC(0)) dut_a (
        .CLK(clk), .RESn(a_resn), .REQ_TGL(a_req), .REQ_A(a_addr), .REQ_D(a_data),
        .ACK_TGL(a_ack), .LS_WADDR(a_waddr), .LS_DIN(a_din), .LS_WE_REQ(a_we_req),
        .LS_WE_ACK(a_we_ack), .BUSY(a_busy), .GRANT(a_grant)
    );

    sdram_ls_arb #(.N(N), .AW(AW), .DW(DW), .ACK_SYNC(2)) dut_b (
        .CLK(clk), .RESn(b_resn), .REQ_TGL(b_req), .REQ_A(b_addr), .REQ_D(b_data),
        .ACK_TGL(b_ack), .LS_WADDR(b_waddr), .LS_DIN(b_din), .LS_WE_REQ(b_we_req),
        .LS_WE_ACK(b_we_ack), .BUSY(b_busy), .GRANT(b_grant)
    );

    int         vectors = 0, errs = 0;
    logic       exp_req, b_exp_req;
    logic [2:0] exp_ack;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        a_addr[i*AW +: AW] = a;
        a_data[i*DW +: DW] = d;
        a_req[i] = ~a_req[i];
    endtask

    // One full write: grant on the next edge, downstream acks at once, ack edge follows.
    task automatic serve(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick;
        exp_req = ~exp_req;
        chk("grant", 64'(a_grant), 64'(g));
        chk("waddr", 64'(a_waddr), 64'(a));
        chk("din", 64'(a_din), 64'(d));
        chk("we_req", 64'(a_we_req), 64'(exp_req));
        chk("busy_set", 64'(a_busy), 64'd1);
        a_we_ack = exp_req;
        tick;
        exp_ack[g] = ~exp_ack[g];
        chk("ack_tgl", 64'(a_ack), 64'(exp_ack));
        chk("busy_clr", 64'(a_busy), 64'd0);
    endtask

    initial begin
        a_resn = 1'b0; a_req = '0; a_addr = '0; a_data = '0; a_we_ack = 1'b0;
        b_resn = 1'b0; b_req = '0; b_addr = '0; b_data = '0; b_we_ack = 1'b0;
        exp_req = 1'b0; exp_ack = '0; b_exp_req = 1'b0;
        tick; tick;
        chk("rst_ack", 64'(a_ack), 64'd0);
        chk("rst_we_req", 64'(a_we_req), 64'd0);
        chk("rst_waddr", 64'(a_waddr), 64'd0);
        chk("rst_din", 64'(a_din), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_grant", 64'(a_grant), 64'd0);
        a_resn = 1'b1;
        tick;
        chk("align_busy", 64'(a_busy), 64'd0);
        chk("align_we_req", 64'(a_we_req), 64'd0);

        // single request from requester 1
        set_req(1, 25'h0100000, 32'hDEADBEEF);
        tick;
        chk("t1_waddr", 64'(a_waddr), 64'h0100000);
        chk("t1_din", 64'(a_din), 64'hDEADBEEF);
        chk("t1_we_req", 64'(a_we_req), 64'd1);
        chk("t1_grant", 64'(a_grant), 64'd1);
        chk("t1_busy", 64'(a_busy), 64'd1);
        chk("t1_ack0", 64'(a_ack), 64'd0);
        tick; tick;
        chk("t1_hold_busy", 64'(a_busy), 64'd1);
        chk("t1_hold_ack", 64'(a_ack), 64'd0);
        a_we_ack = 1'b1;
        tick;
        chk("t1_ack", 64'(a_ack), 64'b010);
        chk("t1_busy_clr", 64'(a_busy), 64'd0);
        chk("t1_waddr_kept", 64'(a_waddr), 64'h0100000);

        // reset, then all three pending at once
        a_resn = 1'b0; a_req = '0; a_we_ack = 1'b0; exp_req = 1'b0; exp_ack = '0;
        #1;
        chk("async_rst_ack", 64'(a_ack), 64'd0);
        chk("async_rst_we_req", 64'(a_we_req), 64'd0);
        chk("async_rst_busy", 64'(a_busy), 64'd0);
        tick;
        set_req(0, 25'h0000010, 32'h11110000);
        set_req(1, 25'h0000020, 32'h22220000);
        set_req(2, 25'h0000030, 32'h33330000);
        a_resn = 1'b1;
        tick;
        chk("align_ignores_req", 64'(a_busy), 64'd0);
        serve(0, 25'h0000010, 32'h11110000);
        serve(1, 25'h0000020, 32'h22220000);
        serve(2, 25'h0000030, 32'h33330000);
        set_req(0, 25'h0000040, 32'h44440000);
        serve(0, 25'h0000040, 32'h44440000);

        // fairness: 0 and 2 keep re-requesting, grants alternate
        set_req(0, 25'h0000100, 32'hA0000000);
        set_req(2, 25'h0000200, 32'hC0000000);
        serve(2, 25'h0000200, 32'hC0000000);
        set_req(2, 25'h0000204, 32'hC0000001);
        serve(0, 25'h0000100, 32'hA0000000);
        set_req(0, 25'h0000104, 32'hA0000001);
        serve(2, 25'h0000204, 32'hC0000001);
        serve(0, 25'h0000104, 32'hA0000001);

        // late arrival of requester 2 while requester 0 is outstanding
        set_req(0, 25'h0000300, 32'h03030303);
        tick;
        exp_req = ~exp_req;
        chk("late_grant0", 64'(a_grant), 64'd0);
        chk("late_waddr0", 64'(a_waddr), 64'h0000300);
        set_req(2, 25'h0000400, 32'h04040404);
        tick; tick;
        chk("late_hold_waddr", 64'(a_waddr), 64'h0000300);
        chk("late_hold_din", 64'(a_din), 64'h03030303);
        chk("late_hold_grant", 64'(a_grant), 64'd0);
        chk("late_hold_we_req", 64'(a_we_req), 64'(exp_req));
        a_we_ack = exp_req;
        tick;
        exp_ack[0] = ~exp_ack[0];
        chk("late_ack0", 64'(a_ack), 64'(exp_ack));
        chk("late_idle_busy", 64'(a_busy), 64'd0);
        chk("late_idle_waddr", 64'(a_waddr), 64'h0000300);
        serve(2, 25'h0000400, 32'h04040404);

        // stale downstream ack left high by a reset mid-transfer
        set_req(1, 25'h0000500, 32'h05050505);
        tick;
        exp_req = ~exp_req;
        chk("stale_grant", 64'(a_grant), 64'd1);
        chk("stale_we_req", 64'(a_we_req), 64'd1);
        a_we_ack = 1'b1; a_resn = 1'b0; a_req = '0;
        #1;
        chk("stale_rst_busy", 64'(a_busy), 64'd0);
        chk("stale_rst_we_req", 64'(a_we_req), 64'd0);
        chk("stale_rst_waddr", 64'(a_waddr), 64'd0);
        tick;
        a_resn = 1'b1;
        tick;
        chk("stale_align_we_req", 64'(a_we_req), 64'd1);
        chk("stale_align_busy", 64'(a_busy), 64'd0);
        chk("stale_align_ack", 64'(a_ack), 64'd0);
        tick; tick;
        chk("stale_no_spurious_ack", 64'(a_ack), 64'd0);
        chk("stale_still_idle", 64'(a_busy), 64'd0);
        exp_req = 1'b1; exp_ack = '0;
        set_req(1, 25'h0000600, 32'h06060606);
        serve(1, 25'h0000600, 32'h06060606);

        // ACK_SYNC=2 instance: latency and 256 back-to-back writes from requester 1
        b_resn = 1'b1;
        tick; tick; tick;
        chk("b_align_we_req", 64'(b_we_req), 64'd0);
        chk("b_align_busy", 64'(b_busy), 64'd0);
        for (int i = 0; i < 256; i++) begin
            int n;
            b_addr[AW +: AW] = AW'(4 * i);
            b_data[DW +: DW] = 32'hA5000000 | 32'(i);
            b_req[1] = ~b_req[1];
            tick;
            b_exp_req = ~b_exp_req;
            chk("b_grant", 64'(b_grant), 64'd1);
            chk("b_waddr", 64'(b_waddr), 64'(4 * i));
            chk("b_din", 64'(b_din), 64'(32'hA5000000 | 32'(i)));
            chk("b_we_req", 64'(b_we_req), 64'(b_exp_req));
            b_we_ack = b_exp_req;
            n = 0;
            do begin
                tick;
                n++;
            end while (b_busy && n < 10);
            chk("b_ack_latency", 64'(n), 64'd3);
            chk("b_no_loss", 64'(b_ack[1]), 64'(b_req[1]));
        end
        chk("b_final_ack", 64'(b_ack), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
